wallace_final_adder: RTL and testbench



---
 rtl/wallace_final_adder_pkg.sv | 26 ++
 rtl/wallace_final_adder_cpa_chunk.sv | 33 +++
 rtl/wallace_final_adder.sv | 150 +++++++++++++++
 tb/tb_wallace_final_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wallace_final_adder_pkg.sv
// ---------------------------------------------------------------------------
// wallace_pkg
// Shared definitions for the Wallace-tree final carry-propagate adder:
//   state_t      - control FSM states (IDLE, ADD, DONE)
//   DEF_WIDTH    - default product width in bits
//   DEF_CHUNK    - default number of bits resolved per ADD cycle
//   idx_width()  - width of the chunk index counter for a given chunk count
// ---------------------------------------------------------------------------
package wallace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // clog2 of the chunk count, never narrower than one bit so a
    // single-chunk build still has a legal counter.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/wallace_final_adder_cpa_chunk.sv
// ---------------------------------------------------------------------------
// cpa_chunk
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  - W-bit addends
//   cin   - carry in to bit 0
//   s     - W-bit sum
//   cout  - carry out of bit W-1
// ---------------------------------------------------------------------------
module cpa_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign s[gi]      = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[W];

endmodule

// File: rtl/wallace_final_adder.sv
// ---------------------------------------------------------------------------
// wallace_final_adder
// Final carry-propagate stage of a Wallace-tree multiplier. Resolves the
// redundant sum/carry vector pair into a binary product, CHUNK bits per
// clock, with the inter-chunk carry kept in a register. Single-entry stage
// with valid/ready on both sides.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - sum_vec/carry_vec valid
//   in_ready   - stage can accept a vector pair (IDLE only)
//   sum_vec    - reduction-tree sum vector, bit i weight 2^i
//   carry_vec  - reduction-tree carry vector, weight-aligned
//   out_valid  - product valid (DONE only)
//   out_ready  - consumer accepts product
//   product    - (sum_vec + carry_vec) mod 2^WIDTH
//   carry_out  - bit WIDTH of the sum; present only when the macro
//                WALLACE_FINAL_ADD_COUT_EN is defined
// ---------------------------------------------------------------------------
module wallace_final_adder
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
`ifdef WALLACE_FINAL_ADD_COUT_EN
    ,
    output logic             carry_out
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = idx_width(NCHUNK);
    localparam logic [KW-1:0] LAST_IDX = KW'(NCHUNK - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_sum;
    logic [WIDTH-1:0]  r_carry;
    logic [WIDTH-1:0]  r_product;
    logic [KW-1:0]     r_idx;
    logic              r_cin;
    logic              r_in_ready;
    logic              r_out_valid;
`ifdef WALLACE_FINAL_ADD_COUT_EN
    logic              r_cout;
`endif

    // Slice the latched vectors into chunks so the single adder can be fed
    // through a plain index mux.
    logic [CHUNK-1:0]  w_sum_chunk   [NCHUNK];
    logic [CHUNK-1:0]  w_carry_chunk [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign w_sum_chunk[gi]   = r_sum[gi*CHUNK +: CHUNK];
            assign w_carry_chunk[gi] = r_carry[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0]  w_a;
    logic [CHUNK-1:0]  w_b;
    logic [CHUNK-1:0]  w_s;
    logic              w_cout;

    assign w_a = w_sum_chunk[r_idx];
    assign w_b = w_carry_chunk[r_idx];

    cpa_chunk #(
        .W (CHUNK)
    ) u_cpa_chunk (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_cin),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_carry     <= '0;
            r_product   <= '0;
            r_idx       <= '0;
            r_cin       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef WALLACE_FINAL_ADD_COUT_EN
            r_cout      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sum      <= sum_vec;
                        r_carry    <= carry_vec;
                        r_idx      <= '0;
                        r_cin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_product[r_idx*CHUNK +: CHUNK] <= w_s;
                    r_cin <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef WALLACE_FINAL_ADD_COUT_EN
                        r_cout      <= w_cout;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
`ifdef WALLACE_FINAL_ADD_COUT_EN
    assign carry_out = r_cout;
`endif

endmodule

// File: tb/tb_wallace_final_adder.sv
// ---------------------------------------------------------------------------
// tb_wallace_final_adder
// Self-checking bench: expected products are queued when a vector pair is
// driven and popped when the stage presents its result.
// ---------------------------------------------------------------------------
module tb_wallace_final_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
`ifdef WALLACE_FINAL_ADD_COUT_EN
    logic             carry_out;
`endif

    wallace_final_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef WALLACE_FINAL_ADD_COUT_EN
        ,
        .carry_out (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] prod;
        logic             cout;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for in_ready, drive the pair for one edge,
    // scramble the inputs afterwards, then watch latency, stall and drain.
    task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                          input int stall, input bit rdy_early);
        int               n;
        exp_t             e;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] p0;

        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        check("in_ready_wait", in_ready, 1);

        full   = {1'b0, s} + {1'b0, c};
        e.prod = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        sb_q.push_back(e);

        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        out_ready = rdy_early;
        tick;
        in_valid  = 1'b0;
        sum_vec   = WIDTH'($urandom);
        carry_vec = WIDTH'($urandom);
        check("busy_in_ready", in_ready, 0);

        n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        check("latency", n, NCHUNK);

        p0 = product;
        if (!rdy_early) begin
            for (int i = 0; i < stall; i++) begin
                tick;
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_product", product, p0);
            end
        end

        if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("product", product, e.prod);
`ifdef WALLACE_FINAL_ADD_COUT_EN
            check("carry_out", carry_out, e.cout);
`endif
        end
        $display("op sum=%04h carry=%04h product=%04h exp=%04h stall=%0d", s, c, product, e.prod, stall);

        out_ready = 1'b1;
        tick;
        check("drop_valid", out_valid, 0);
        check("idle_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;

        // out_ready high while idle must not produce anything
        out_ready = 1'b1;
        repeat (3) tick;
        check("idle_no_valid", out_valid, 0);
        out_ready = 1'b0;

        run_op(16'h00FF, 16'h0001, 0, 1'b1);
        run_op(16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 10, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 2, 1'b0);

        // Reset in the second ADD cycle discards the operation
        sum_vec   = 16'h0F0F;
        carry_vec = 16'h00F1;
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_product", product, 0);
        tick;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (NCHUNK + 3) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        $display("op reset-abort sum=0f0f carry=00f1 discarded");

        run_op(16'h0002, 16'h0003, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
